// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9
`ifdef MC_CTRL_ADDI_EN
    ,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALUOp/Funct to ALUControl decode; funct_valid_o flags the supported R-type functs.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       funct_valid_o
);

  logic [2:0] funct_ctrl_s;

  always_comb begin
    funct_ctrl_s  = ALUC_ADD;
    funct_valid_o = 1'b0;
    case (funct_i)
      FUNCT_ADD: begin funct_ctrl_s = ALUC_ADD; funct_valid_o = 1'b1; end
      FUNCT_SUB: begin funct_ctrl_s = ALUC_SUB; funct_valid_o = 1'b1; end
      FUNCT_AND: begin funct_ctrl_s = ALUC_AND; funct_valid_o = 1'b1; end
      FUNCT_OR:  begin funct_ctrl_s = ALUC_OR;  funct_valid_o = 1'b1; end
      FUNCT_SLT: begin funct_ctrl_s = ALUC_SLT; funct_valid_o = 1'b1; end
      default:   begin funct_ctrl_s = ALUC_ADD; funct_valid_o = 1'b0; end
    endcase
  end

  always_comb begin
    case (alu_op_i)
      ALUOP_ADD:   alu_control_o = ALUC_ADD;
      ALUOP_SUB:   alu_control_o = ALUC_SUB;
      ALUOP_FUNCT: alu_control_o = funct_ctrl_s;
      default:     alu_control_o = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with retired-instruction counter.
// Optional addi support is enabled by defining MC_CTRL_ADDI_EN.
module mc_controller
  import mips_pkg::*;
#(
  parameter int CountWidth = 32
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [5:0]            Op,
  input  logic [5:0]            Funct,
  input  logic                  Zero,
  output logic                  IorD,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegDst,
  output logic                  MemtoReg,
  output logic                  RegWrite,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ALUControl,
  output logic [1:0]            PCSrc,
  output logic                  PCEn,
  output logic                  Illegal,
  output logic                  Retire,
  output logic [CountWidth-1:0] InstrCount
);

  state_e                state_q, state_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [1:0]            alu_op_s;
  logic                  funct_valid_s;
  logic                  illegal_s, pcwrite_s, branch_s, retire_s;
  logic                  memwrite_s, irwrite_s, regwrite_s;

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op_s),
    .funct_i       (Funct),
    .alu_control_o (ALUControl),
    .funct_valid_o (funct_valid_s)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count_d = retire_s ? count_q + {{(CountWidth-1){1'b0}}, 1'b1} : count_q;

  always_comb begin
    state_d   = state_q;
    illegal_s = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_valid_s) begin
              state_d = S_EXECUTE;
            end else begin
              state_d   = S_FETCH;
              illegal_s = 1'b1;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI: state_d = S_ADDIEX;
`endif
          OP_J:    state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
`endif
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    IorD       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    regwrite_s = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    alu_op_s   = ALUOP_ADD;
    PCSrc      = PCSRC_ALU;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    retire_s   = 1'b0;
    case (state_q)
      S_FETCH:   begin irwrite_s = 1'b1; pcwrite_s = 1'b1; ALUSrcB = SRCB_FOUR; end
      S_DECODE:  ALUSrcB = SRCB_IMMSH;
      S_MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
      S_MEMRD:   IorD = 1'b1;
      S_MEMWB:   begin regwrite_s = 1'b1; MemtoReg = 1'b1; retire_s = 1'b1; end
      S_MEMWR:   begin IorD = 1'b1; memwrite_s = 1'b1; retire_s = 1'b1; end
      S_EXECUTE: begin ALUSrcA = 1'b1; alu_op_s = ALUOP_FUNCT; end
      S_ALUWB:   begin regwrite_s = 1'b1; RegDst = 1'b1; retire_s = 1'b1; end
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX:  begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
      S_ADDIWB:  begin regwrite_s = 1'b1; retire_s = 1'b1; end
`endif
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        alu_op_s = ALUOP_SUB;
        branch_s = 1'b1;
        PCSrc    = PCSRC_ALUOUT;
        retire_s = 1'b1;
      end
      S_JUMP:    begin pcwrite_s = 1'b1; PCSrc = PCSRC_JUMP; retire_s = 1'b1; end
      default:   ALUSrcB = SRCB_FOUR;
    endcase
  end

  // Strobes are gated by reset so nothing fires while the FSM is parked in FETCH under reset.
  assign IRWrite    = irwrite_s & RST;
  assign MemWrite   = memwrite_s & RST;
  assign RegWrite   = regwrite_s & RST;
  assign Retire     = retire_s & RST;
  assign Illegal    = illegal_s & RST;
  assign PCEn       = (pcwrite_s | (branch_s & Zero)) & RST;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction behavioural model plus directed literal checks.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       RST;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn, Illegal, Retire;
  logic [3:0] InstrCount;

  always #5 clk = ~clk;

  mc_controller #(.CountWidth(4)) dut (
    .clk(clk), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal),
    .Retire(Retire), .InstrCount(InstrCount)
  );

  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctl;
    logic [1:0] pcsrc;
    logic       pcen, illegal, retire;
  } out_t;

  localparam int K_ILL = 0, K_LW = 1, K_SW = 2, K_R = 3, K_ADDI = 4, K_BEQ = 5, K_J = 6;

  int         errors = 0;
  int         checks = 0;
  int         model_cnt = 0;
  int         cyc = 1;
  bit         chk_en = 1'b0;
  logic [5:0] cur_op = 6'd0, cur_funct = 6'd0;
  logic       cur_zero = 1'b0;

  function automatic logic [2:0] funct_code(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'bxxx;
    endcase
  endfunction

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] f);
    case (op)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) ? K_R : K_ILL;
      6'b000100: return K_BEQ;
`ifdef MC_CTRL_ADDI_EN
      6'b001000: return K_ADDI;
`endif
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic int lat_of(input int kind);
    case (kind)
      K_LW:    return 5;
      K_SW, K_R, K_ADDI: return 4;
      K_BEQ, K_J: return 3;
      default: return 2;
    endcase
  endfunction

  // Expected outputs for cycle k (1 = fetch) of one instruction.
  function automatic out_t model(input logic [5:0] op, input logic [5:0] f, input logic z, input int k);
    out_t e;
    int   kind;
    e = '0;
    e.aluctl = 3'b010;
    kind = kind_of(op, f);
    if (k == 1) begin
      e.irwrite = 1'b1; e.pcen = 1'b1; e.alusrcb = 2'b01;
    end else if (k == 2) begin
      e.alusrcb = 2'b11; e.illegal = (kind == K_ILL);
    end else begin
      case (kind)
        K_LW, K_SW, K_ADDI: begin
          if (k == 3) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
          else if (kind == K_LW && k == 4) e.iord = 1'b1;
          else if (kind == K_LW) begin e.regwrite = 1'b1; e.memtoreg = 1'b1; e.retire = 1'b1; end
          else if (kind == K_SW) begin e.iord = 1'b1; e.memwrite = 1'b1; e.retire = 1'b1; end
          else begin e.regwrite = 1'b1; e.retire = 1'b1; end
        end
        K_R: begin
          if (k == 3) begin e.alusrca = 1'b1; e.aluctl = funct_code(f); end
          else begin e.regwrite = 1'b1; e.regdst = 1'b1; e.retire = 1'b1; end
        end
        K_BEQ: begin
          e.alusrca = 1'b1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pcen = z; e.retire = 1'b1;
        end
        K_J:     begin e.pcen = 1'b1; e.pcsrc = 2'b10; e.retire = 1'b1; end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model while an instruction is in flight.
  always @(negedge clk) begin
    out_t act, exp;
    if (chk_en) begin
      exp = model(cur_op, cur_funct, cur_zero, cyc);
      act = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
             ALUControl, PCSrc, PCEn, Illegal, Retire};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL outputs op=%b funct=%b cyc=%0d act=%h req=%h", cur_op, cur_funct, cyc, act, exp);
      end
      checks++;
      if (InstrCount !== 4'(model_cnt)) begin
        errors++;
        $display("FAIL count op=%b cyc=%0d act=%0d req=%0d", cur_op, cyc, InstrCount, model_cnt);
      end
    end
  end

  // Entered at posedge+1 with the FSM in FETCH; abort_at>0 asserts reset in that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z, input int abort_at);
    int kind, lat;
    kind = kind_of(op, f);
    lat  = lat_of(kind);
    Op = op; Funct = f; Zero = z;
    cur_op = op; cur_funct = f; cur_zero = z;
    chk_en = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      cyc = k;
      @(negedge clk); #1;
      if (kind == K_LW && k == 4) chk("lw_no_early_wb", 8'({RegWrite, Retire}), 8'd0);
      if (kind == K_LW && k == 5) chk("lw_wb", 8'({RegWrite, MemtoReg, Retire}), 8'd7);
      if (kind == K_SW && k == 4) chk("sw_memwrite", 8'(MemWrite), 8'd1);
      if (kind == K_R && f == 6'b101010 && k == 3) chk("slt_aluctl", 8'(ALUControl), 8'd7);
      if (kind == K_R && k == 4) chk("r_wb", 8'({RegWrite, RegDst}), 8'd3);
      if (kind == K_BEQ && k == 3 && z) chk("beq_taken", 8'(PCEn), 8'd1);
      if (kind == K_BEQ && k == 3 && !z) chk("beq_not_taken", 8'(PCEn), 8'd0);
      if (kind == K_ILL && k == 2) chk("illegal_pulse", 8'({Illegal, RegWrite}), 8'd2);
      if (kind == K_J && k == 3) chk("j_retire", 8'(Retire), 8'd1);
      if (k == abort_at) begin
        chk_en = 1'b0;
        #1 RST = 1'b0;
        #1;
        chk("rst_memwrite", 8'(MemWrite), 8'd0);
        chk("rst_strobes", 8'({IRWrite, RegWrite, PCEn, Retire, Illegal}), 8'd0);
        chk("rst_muxes", 8'({IorD, ALUSrcB}), 8'd1);
        chk("rst_count", 8'(InstrCount), 8'd0);
        @(posedge clk); #1;
        chk("rst_hold", 8'({IRWrite, MemWrite, PCEn}), 8'd0);
        RST = 1'b1;
        model_cnt = 0;
        return;
      end
      @(posedge clk); #1;
    end
    if (kind != K_ILL) model_cnt = (model_cnt + 1) % 16;
  endtask

  initial begin
    RST = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
    #1 RST = 1'b0;
    #1;
    chk("reset_strobes", 8'({IRWrite, PCEn, RegWrite, MemWrite, Illegal, Retire}), 8'd0);
    chk("reset_muxes", 8'({IorD, ALUSrcA, ALUSrcB, PCSrc}), 8'b0000_0100);
    chk("reset_count", 8'(InstrCount), 8'd0);
    repeat (2) @(posedge clk);
    #1 RST = 1'b1;

    run_instr(6'b100011, 6'b000000, 1'b1, 0);
    chk("count_after_lw", 8'(InstrCount), 8'd1);
    run_instr(6'b101011, 6'b000000, 1'b1, 0);
    run_instr(6'b000000, 6'b100000, 1'b1, 0);
    run_instr(6'b000000, 6'b101010, 1'b0, 0);
    chk("count_after_slt", 8'(InstrCount), 8'd4);
    run_instr(6'b000000, 6'b100010, 1'b1, 0);
    run_instr(6'b000000, 6'b100100, 1'b0, 0);
    run_instr(6'b000000, 6'b100101, 1'b1, 0);
    run_instr(6'b000100, 6'b000000, 1'b1, 0);
    run_instr(6'b000100, 6'b000000, 1'b0, 0);
    chk("count_after_beq", 8'(InstrCount), 8'd9);
    run_instr(6'b001000, 6'b000000, 1'b1, 0);
    run_instr(6'b111111, 6'b000000, 1'b1, 0);
    run_instr(6'b000000, 6'b000111, 1'b1, 0);
`ifdef MC_CTRL_ADDI_EN
    chk("count_after_illegal", 8'(InstrCount), 8'd10);
`else
    chk("count_after_illegal", 8'(InstrCount), 8'd9);
`endif
    run_instr(6'b000010, 6'b000000, 1'b0, 0);

    run_instr(6'b101011, 6'b000000, 1'b0, 4);
    chk("count_after_abort", 8'(InstrCount), 8'd0);

    for (int i = 0; i < 15; i++) run_instr(6'b000010, 6'b000000, 1'b0, 0);
    chk("count_full", 8'(InstrCount), 8'd15);
    run_instr(6'b000010, 6'b000000, 1'b1, 0);
    chk_en = 1'b0;
    chk("count_wrap", 8'(InstrCount), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
